// File: rtl/pipeline_stall_controller.sv
// rtl/pipeline_stall_controller.sv - load-use stall / branch flush hazard controller
// Requests act combinationally in the cycle they are presented; multi-cycle sequences run from a down counter.
module pipeline_stall_controller #(
    parameter int unsigned STALL_CYCLES = 1,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  nop,
    input  logic [1:0]  flush,
    output logic        pc_write_en,
    output logic        pc_redirect,
    output logic        if_id_write_en,
    output logic        if_id_clear,
    output logic        id_ex_clear,
    output logic        busy,
    output logic [15:0] stall_count,
    output logic [15:0] flush_count,
    output logic        err_sticky
);

    typedef enum logic [1:0] {
        RUN     = 2'b00,
        STALL   = 2'b01,
        FLUSH   = 2'b10,
        ILLEGAL = 2'b11
    } state_t;

    localparam logic [2:0] STALL_RELOAD = 3'(STALL_CYCLES - 1);
    localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);

    state_t     state, state_nxt;
    logic [2:0] cnt, cnt_nxt;
    logic       flush_req, nop_req;
    logic       stall_inc, flush_inc;

    // Reserved encodings (2'b1x) never qualify as requests.
    assign flush_req = (flush == 2'b01);
    assign nop_req   = (nop == 2'b01);

    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        pc_write_en    = 1'b1;
        if_id_write_en = 1'b1;
        pc_redirect    = 1'b0;
        if_id_clear    = 1'b0;
        id_ex_clear    = 1'b0;
        busy           = 1'b0;
        stall_inc      = 1'b0;
        flush_inc      = 1'b0;

        if (rst) begin
            pc_write_en    = 1'b0;
            if_id_write_en = 1'b0;
            if_id_clear    = 1'b1;
            id_ex_clear    = 1'b1;
            state_nxt      = RUN;
            cnt_nxt        = 3'd0;
        end else begin
            busy = (state == STALL) || (state == FLUSH);
            if (flush_req) begin
                pc_redirect = 1'b1;
                if_id_clear = 1'b1;
                id_ex_clear = 1'b1;
                flush_inc   = 1'b1;
                if (FLUSH_CYCLES > 1) begin
                    state_nxt = FLUSH;
                    cnt_nxt   = FLUSH_RELOAD;
                end else begin
                    state_nxt = RUN;
                    cnt_nxt   = 3'd0;
                end
            end else begin
                case (state)
                    STALL: begin
                        pc_write_en    = 1'b0;
                        if_id_write_en = 1'b0;
                        id_ex_clear    = 1'b1;
                        if (cnt <= 3'd1) begin
                            state_nxt = RUN;
                            cnt_nxt   = 3'd0;
                        end else begin
                            cnt_nxt = cnt - 3'd1;
                        end
                    end
                    FLUSH: begin
                        if_id_clear = 1'b1;
                        id_ex_clear = 1'b1;
                        if (cnt <= 3'd1) begin
                            state_nxt = RUN;
                            cnt_nxt   = 3'd0;
                        end else begin
                            cnt_nxt = cnt - 3'd1;
                        end
                    end
                    default: begin
                        // RUN, and the unreachable encoding which recovers as RUN.
                        state_nxt = RUN;
                        cnt_nxt   = 3'd0;
                        if (nop_req) begin
                            pc_write_en    = 1'b0;
                            if_id_write_en = 1'b0;
                            id_ex_clear    = 1'b1;
                            stall_inc      = 1'b1;
                            if (STALL_CYCLES > 1) begin
                                state_nxt = STALL;
                                cnt_nxt   = STALL_RELOAD;
                            end
                        end
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RUN;
            cnt         <= 3'd0;
            stall_count <= 16'd0;
            flush_count <= 16'd0;
            err_sticky  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (stall_inc && (stall_count != 16'hFFFF))
                stall_count <= stall_count + 16'd1;
            if (flush_inc && (flush_count != 16'hFFFF))
                flush_count <= flush_count + 16'd1;
            err_sticky <= err_sticky | nop[1] | flush[1];
        end
    end

endmodule

// File: doc/pipeline_stall_controller.md
PIPELINE_STALL_CONTROLLER -- requirements
Module: pipeline_stall_controller

Interface
REQ-001 SHALL have parameter STALL_CYCLES, default 1, bubble cycles per load-use stall (legal 1..7).
REQ-002 SHALL have parameter FLUSH_CYCLES, default 2, squash cycles per taken branch (legal 1..7).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port nop  input  2  hazard request; 2'b01 = load-use stall, 2'b00 = none, 2'b1x reserved.
REQ-006 SHALL have port flush  input  2  hazard request; 2'b01 = bne taken, 2'b00 = none, 2'b1x reserved.
REQ-007 SHALL have port pc_write_en  output  1  PC register update enable.
REQ-008 SHALL have port pc_redirect  output  1  selects branch target into PC this cycle.
REQ-009 SHALL have port if_id_write_en  output  1  Fetch-Decode register load enable.
REQ-010 SHALL have port if_id_clear  output  1  zero the Fetch-Decode register.
REQ-011 SHALL have port id_ex_clear  output  1  insert bubble into the Decode-Execute register.
REQ-012 SHALL have port busy  output  1  high while the state is not RUN.
REQ-013 SHALL have port stall_count  output  16  accepted stall requests.
REQ-014 SHALL have port flush_count  output  16  accepted flush requests.
REQ-015 SHALL have port err_sticky  output  1  a reserved encoding was seen since reset.

Function
REQ-016 SHALL implement states RUN=2'b00, STALL=2'b01, FLUSH=2'b10, plus a 3-bit down counter cnt.
REQ-017 SHALL decode the control outputs combinationally from the current state, cnt, nop and flush, so a request acts in the same cycle it is presented (zero latency).
REQ-018 SHALL treat nop or flush of 2'b10/2'b11 as 2'b00 and set err_sticky on the next edge.
REQ-019 SHALL give flush priority over nop in every state.
REQ-020 SHALL, in RUN with no request, drive pc_write_en=1 and if_id_write_en=1, with pc_redirect, if_id_clear and id_ex_clear at 0.
REQ-021 SHALL, on an accepted flush (flush=2'b01 in any state), drive pc_redirect=1, pc_write_en=1, if_id_write_en=1, if_id_clear=1 and id_ex_clear=1 that cycle, and increment flush_count.
REQ-022 SHALL, after an accepted flush, go next to FLUSH with cnt=FLUSH_CYCLES-1 if FLUSH_CYCLES>1, else go to RUN.
REQ-023 SHALL, on a stall accepted in RUN (nop=2'b01, no flush), drive pc_write_en=0, if_id_write_en=0 and id_ex_clear=1, and increment stall_count.
REQ-024 SHALL, after a stall accepted in RUN, go next to STALL with cnt=STALL_CYCLES-1 if STALL_CYCLES>1, else stay in RUN.
REQ-025 SHALL, in STALL without flush, drive the stall outputs of REQ-023 without counting, decrement cnt, and return to RUN after the cycle where cnt==1.
REQ-026 SHALL, in STALL, ignore nop=2'b01 (no count, no extension).
REQ-027 SHALL, in FLUSH without flush, drive pc_write_en=1, if_id_write_en=1, if_id_clear=1, id_ex_clear=1 and pc_redirect=0, decrement cnt, and return to RUN after cnt==1.
REQ-028 SHALL, in FLUSH, ignore nop.
REQ-029 SHALL, when flush arrives in STALL, abort the stall and apply REQ-021/022.
REQ-030 SHALL, when flush arrives in FLUSH, redirect again and reload cnt per REQ-022.
REQ-031 SHALL saturate stall_count and flush_count at 16'hFFFF (no wrap).
REQ-032 SHALL force any unreachable state (2'b11) to RUN on the next edge, with outputs as in RUN.

Reset
REQ-033 SHALL, while rst=1 at an edge, set state=RUN, cnt=0, stall_count=0, flush_count=0 and err_sticky=0, overriding any same-cycle request.
REQ-034 SHALL, while rst=1, drive pc_write_en=0, if_id_write_en=0, pc_redirect=0, if_id_clear=1, id_ex_clear=1 and busy=0.
REQ-035 SHALL, when rst is asserted mid-STALL or mid-FLUSH, abandon the sequence with no residual cycles after reset drops.

Verification
REQ-036 SHALL cover: defaults, single cycle nop=01 in RUN -> pc_write_en=0, if_id_write_en=0, id_ex_clear=1 that cycle only; busy stays 0; stall_count=1.
REQ-037 SHALL cover: flush=01 pulse with FLUSH_CYCLES=2 -> cycle0 pc_redirect=1 with clears; cycle1 busy=1, if_id_clear=1, pc_redirect=0; cycle2 RUN; flush_count=1.
REQ-038 SHALL cover: nop=01 and flush=01 together -> flush behaviour only; flush_count=1, stall_count=0.
REQ-039 SHALL cover: STALL_CYCLES=3, nop pulse, then flush on the 2nd stall cycle -> stall aborted, redirect that cycle, stall_count=1, flush_count=1.
REQ-040 SHALL cover: nop=2'b11 -> outputs as idle RUN, err_sticky=1 next cycle and held until rst; rst during FLUSH -> RUN, counters 0.
REQ-041 SHALL cover: 65537 flush pulses -> flush_count holds at 16'hFFFF.
